// File: rtl/div_issue_ctrl_if.sv
// Divider issue bundle between ID/WB and div_issue_ctrl.
// master = pipeline side, slave = controller side.
interface div_issue_ctrl_if;
  logic       div_ID;
  logic [4:0] rd_ID;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       rs1use_ID;
  logic       rs2use_ID;
  logic       rduse_ID;
  logic       flush_ID;
  logic       reg_write_WB;
  logic       div_start;
  logic       div_busy;
  logic [4:0] div_rd;
  logic       stall_ID;
  logic       stall_all;
  logic       wb_grant_div;

  modport master (
    output div_ID, rd_ID, rs1_ID, rs2_ID,
    output rs1use_ID, rs2use_ID, rduse_ID,
    output flush_ID, reg_write_WB,
    input  div_start, div_busy, div_rd,
    input  stall_ID, stall_all, wb_grant_div
  );

  modport slave (
    input  div_ID, rd_ID, rs1_ID, rs2_ID,
    input  rs1use_ID, rs2use_ID, rduse_ID,
    input  flush_ID, reg_write_WB,
    output div_start, div_busy, div_rd,
    output stall_ID, stall_all, wb_grant_div
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Multi-cycle divider issue, interlock and WB-port arbitration.
// DIV_STARVE_GUARD_EN enables the writeback starvation force path.
module div_issue_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  div_issue_ctrl_if.slave  bus
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 31 ||
      STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("div_issue_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] CNT_INIT = 5'(DIV_CYCLES - 1);

  state_t     state;
  logic [4:0] cnt;
  logic [3:0] starve;
  logic [4:0] rd_q;

  logic busy;
  logic accept;
  logic force_wb;
  logic grant;
  logic rd_nz;
  logic hazard_rs;
  logic waw;
  logic struct_hz;
  logic stall;

`ifdef DIV_STARVE_GUARD_EN
  assign force_wb = (state == DONE) &&
                    (starve == 4'(STARVE_MAX));
`else
  assign force_wb = 1'b0;
`endif

  assign busy   = (state == RUN) || (state == DONE);
  assign grant  = (state == DONE) &&
                  (!bus.reg_write_WB || force_wb);
  assign accept = (state == IDLE) && bus.div_ID &&
                  !bus.flush_ID && !force_wb;

  // x0 never carries a real dependency
  assign rd_nz     = |rd_q;
  assign hazard_rs = rd_nz &&
    ((bus.rs1use_ID && bus.rs1_ID == rd_q) ||
     (bus.rs2use_ID && bus.rs2_ID == rd_q));
  assign waw       = rd_nz && bus.rduse_ID &&
                     (bus.rd_ID == rd_q);
  assign struct_hz = bus.div_ID && (state != IDLE);
  assign stall     = busy && !bus.flush_ID &&
                     (hazard_rs || waw || struct_hz);

  assign bus.div_start    = rst_n && accept;
  assign bus.stall_ID     = rst_n && stall;
  assign bus.stall_all    = rst_n && force_wb;
  assign bus.wb_grant_div = rst_n && grant;
  assign bus.div_busy     = busy;
  assign bus.div_rd       = rd_q;

  // issue / countdown / writeback-wait sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      starve <= '0;
      rd_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rd_q  <= bus.rd_ID;
            cnt   <= CNT_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == 5'd0) begin
            state  <= DONE;
            starve <= '0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          if (grant) begin
            state <= IDLE;
          end else if (starve != 4'hF) begin
            starve <= starve + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl.
// Grants are matched against a scoreboard of expected rd/cycle.
module tb_div_issue_ctrl;
  localparam int DC = 8;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_issue_ctrl_if bus ();

  div_issue_ctrl #(
    .DIV_CYCLES(DC),
    .STARVE_MAX(SM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] rd;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       div;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic       rdu;
    logic       fl;
    logic       stall;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[7];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic       s_start;
  logic       s_busy;
  logic       s_stall;
  logic       s_sall;
  logic       s_grant;
  logic [4:0] s_rd;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // one clock: sample at negedge, score grants, advance
  task automatic cycle();
    int   cur;
    exp_t e;
    @(negedge clk);
    cur     = cyc;
    s_start = bus.div_start;
    s_busy  = bus.div_busy;
    s_stall = bus.stall_ID;
    s_sall  = bus.stall_all;
    s_grant = bus.wb_grant_div;
    s_rd    = bus.div_rd;
    if (s_grant) begin
      if (sbq.size() == 0) begin
        chk("unexpected_grant", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("grant_rd", int'(s_rd), int'(e.rd));
        chk("grant_cycle", cur, e.cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_in();
    bus.div_ID       = 1'b0;
    bus.rd_ID        = 5'd0;
    bus.rs1_ID       = 5'd0;
    bus.rs2_ID       = 5'd0;
    bus.rs1use_ID    = 1'b0;
    bus.rs2use_ID    = 1'b0;
    bus.rduse_ID     = 1'b0;
    bus.flush_ID     = 1'b0;
    bus.reg_write_WB = 1'b0;
  endtask

  task automatic launch(input logic [4:0] rd,
                        input bit push,
                        input int extra,
                        output int t);
    bus.div_ID   = 1'b1;
    bus.rd_ID    = rd;
    bus.rduse_ID = 1'b1;
    t = cyc;
    if (push) sbq.push_back('{rd, t + DC + 1 + extra});
    cycle();
    chk("launch_start", int'(s_start), 1);
    idle_in();
  endtask

  task automatic apply(input vec_t v);
    bus.div_ID    = v.div;
    bus.rd_ID     = v.rd;
    bus.rs1_ID    = v.rs1;
    bus.rs2_ID    = v.rs2;
    bus.rs1use_ID = v.rs1u;
    bus.rs2use_ID = v.rs2u;
    bus.rduse_ID  = v.rdu;
    bus.flush_ID  = v.fl;
  endtask

  initial begin
    int t;
    int extra;
    tbl[0] = '{1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 5'd8, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    idle_in();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // reset: a divide request must not launch
    bus.div_ID = 1'b1;
    bus.rd_ID  = 5'd9;
    cycle();
    chk("rst_start", int'(s_start), 0);
    cycle();
    chk("rst_start2", int'(s_start), 0);
    chk("rst_grant", int'(s_grant), 0);
    idle_in();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_busy", int'(s_busy), 0);
    chk("post_rst_rd", int'(s_rd), 0);
    chk("post_rst_stall", int'(s_stall), 0);
    chk("post_rst_sall", int'(s_sall), 0);

    // table of ID patterns against div x5 in RUN
    launch(5'd5, 1'b1, 0, t);
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i]);
      cycle();
      chk($sformatf("tbl%0d_stall", i), int'(s_stall), int'(tbl[i].stall));
      chk($sformatf("tbl%0d_start", i), int'(s_start), 0);
      chk($sformatf("tbl%0d_busy", i), int'(s_busy), 1);
    end
    idle_in();
    cycle();
    chk("t8_grant", int'(s_grant), 0);
    cycle();
    chk("t9_grant", int'(s_grant), 1);
    chk("t9_sall", int'(s_sall), 0);
    cycle();
    chk("t10_busy", int'(s_busy), 0);

    // dependent reader of x5 held through grant
    launch(5'd5, 1'b1, 0, t);
    bus.rs1use_ID = 1'b1;
    bus.rs1_ID    = 5'd5;
    for (int k = 1; k <= DC + 1; k++) begin
      cycle();
      chk($sformatf("dep_stall_k%0d", k), int'(s_stall), 1);
    end
    cycle();
    chk("dep_release", int'(s_stall), 0);
    chk("dep_idle", int'(s_busy), 0);
    idle_in();

    // same with a divide writing x0
    launch(5'd0, 1'b1, 0, t);
    bus.rs1use_ID = 1'b1;
    bus.rs1_ID    = 5'd0;
    bus.rduse_ID  = 1'b1;
    bus.rd_ID     = 5'd0;
    for (int k = 1; k <= DC + 1; k++) begin
      cycle();
      chk($sformatf("x0_stall_k%0d", k), int'(s_stall), 0);
    end
    idle_in();
    cycle();
    chk("x0_idle", int'(s_busy), 0);

    // back-to-back divides
    launch(5'd5, 1'b1, 0, t);
    bus.div_ID   = 1'b1;
    bus.rd_ID    = 5'd6;
    bus.rduse_ID = 1'b1;
    for (int k = 1; k <= DC + 1; k++) begin
      cycle();
      chk($sformatf("b2b_stall_k%0d", k), int'(s_stall), 1);
      chk($sformatf("b2b_start_k%0d", k), int'(s_start), 0);
    end
    sbq.push_back('{5'd6, cyc + DC + 1});
    cycle();
    chk("b2b_start2", int'(s_start), 1);
    chk("b2b_nostall", int'(s_stall), 0);
    idle_in();
    cycle();
    chk("b2b_rd6", int'(s_rd), 6);
    chk("b2b_busy", int'(s_busy), 1);
    repeat (DC) cycle();
    cycle();
    chk("b2b_idle", int'(s_busy), 0);

    // writeback starvation
`ifdef DIV_STARVE_GUARD_EN
    extra = SM;
`else
    extra = 7;
`endif
    launch(5'd5, 1'b1, extra, t);
    bus.reg_write_WB = 1'b1;
    repeat (DC) cycle();
    for (int k = 0; k < extra; k++) begin
      cycle();
      chk($sformatf("starve_deny%0d", k), int'(s_grant), 0);
      chk($sformatf("starve_sall%0d", k), int'(s_sall), 0);
      chk($sformatf("starve_busy%0d", k), int'(s_busy), 1);
    end
`ifndef DIV_STARVE_GUARD_EN
    bus.reg_write_WB = 1'b0;
`endif
    cycle();
    chk("starve_grant", int'(s_grant), 1);
`ifdef DIV_STARVE_GUARD_EN
    chk("starve_force_sall", int'(s_sall), 1);
`else
    chk("starve_nosall", int'(s_sall), 0);
`endif
    idle_in();
    cycle();
    chk("starve_idle", int'(s_busy), 0);

    // flush together with div in IDLE
    bus.div_ID   = 1'b1;
    bus.flush_ID = 1'b1;
    bus.rd_ID    = 5'd3;
    cycle();
    chk("flush_idle_start", int'(s_start), 0);
    chk("flush_idle_stall", int'(s_stall), 0);
    idle_in();
    cycle();
    chk("flush_idle_busy", int'(s_busy), 0);

    // flush during RUN does not disturb the count
    launch(5'd5, 1'b1, 0, t);
    repeat (2) cycle();
    bus.flush_ID  = 1'b1;
    bus.div_ID    = 1'b1;
    bus.rs1use_ID = 1'b1;
    bus.rs1_ID    = 5'd5;
    cycle();
    chk("flush_run_stall", int'(s_stall), 0);
    chk("flush_run_start", int'(s_start), 0);
    idle_in();
    repeat (5) cycle();
    cycle();
    chk("flush_run_grant", int'(s_grant), 1);
    cycle();
    chk("flush_run_idle", int'(s_busy), 0);

    // reset while RUN with cnt==3
    launch(5'd5, 1'b0, 0, t);
    bus.rs1use_ID = 1'b1;
    bus.rs1_ID    = 5'd5;
    repeat (4) cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_run_stall", int'(s_stall), 0);
    chk("rst_run_grant", int'(s_grant), 0);
    rst_n = 1'b1;
    cycle();
    chk("rst_run_busy", int'(s_busy), 0);
    chk("rst_run_rd", int'(s_rd), 0);
    chk("rst_run_stall2", int'(s_stall), 0);
    chk("rst_run_sall", int'(s_sall), 0);
    chk("rst_run_grant2", int'(s_grant), 0);
    idle_in();
    repeat (12) cycle();
    chk("rst_run_quiet", int'(s_busy), 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
